// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
// Two-requester round-robin arbiter and sequencer in front of a single-port
// data memory (write on falling clock edge, combinational read).
// Requester 0 is the pipeline MEM stage, requester 1 the loader/debug port.
// Each accepted request runs IDLE -> ACCESS -> RESP, so a transaction takes
// three cycles and responses come back as a one-cycle pulse.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata request from requester N (hold until ready)
//   reqN_ready                 request N accepted this cycle (IDLE only)
//   respN_valid/respN_rdata    response pulse and read data for requester N
//   resp_err                   with respN_valid: address out of range
//   mem_MemWrite/Memread       memory write/read enables (ACCESS only)
//   mem_address/mem_writeData  memory address and write data (ACCESS only)
//   mem_readData               memory read data (combinational)
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp_err,
  output logic              mem_MemWrite,
  output logic              mem_Memread,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Latched transaction; err marks an out-of-range address (no access).
  typedef struct packed {
    logic              write;
    logic              id;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  state_t            state;
  state_t            state_next;
  logic              rr_ptr;   // requester preferred when both are valid
  txn_t              txn;
  logic [DATA_W-1:0] rdata;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] sel_addr;

  assign sel_addr = grant1 ? req1_addr : req0_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, arbitration and output decode.
  always_comb begin
    state_next    = state;
    grant0        = 1'b0;
    grant1        = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    resp0_valid   = 1'b0;
    resp1_valid   = 1'b0;
    resp0_rdata   = '0;
    resp1_rdata   = '0;
    resp_err      = 1'b0;
    mem_MemWrite  = 1'b0;
    mem_Memread   = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant0 = ~rr_ptr;
          grant1 = rr_ptr;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
        // Nothing is accepted while reset is held.
        if (reset) begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        state_next = RESP;
        if (!txn.err) begin
          mem_address = txn.addr;
          if (txn.write) begin
            // Gated so no write reaches memory while reset is high.
            mem_MemWrite  = ~reset;
            mem_writeData = txn.wdata;
          end else begin
            mem_Memread = 1'b1;
          end
        end
      end

      RESP: begin
        state_next = IDLE;
        if (!reset) begin
          resp_err = txn.err;
          if (txn.id) begin
            resp1_valid = 1'b1;
            resp1_rdata = rdata;
          end else begin
            resp0_valid = 1'b1;
            resp0_rdata = rdata;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Transaction latch, round-robin pointer and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
      txn    <= '0;
      rdata  <= '0;
    end else begin
      if (grant0 || grant1) begin
        // Prefer the other requester next time.
        rr_ptr    <= grant0;
        txn.id    <= grant1;
        txn.write <= grant1 ? req1_write : req0_write;
        txn.addr  <= sel_addr;
        txn.wdata <= grant1 ? req1_wdata : req0_wdata;
        txn.err   <= (sel_addr >= MEM_LIMIT);
      end
      if (state == ACCESS) begin
        rdata <= (!txn.err && !txn.write) ? mem_readData : '0;
      end
    end
  end

endmodule
